// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   Mode-0 SPI slave (SCLK idle low, sample on rise, shift on fall), LSB first,
//   oversampled by the system clock. SCLK, CS_N and MOSI are synchronised into
//   the CLK domain and their edges detected there, so SCLK high and low phases
//   must each last at least four CLK periods.
//
// Ports
//   CLK      system clock, all state changes on its rising edge
//   CLR      asynchronous active-high reset
//   SCLK     serial clock from the master
//   CS_N     active-low chip select from the master
//   MOSI     serial data from the master
//   MISO     serial data to the master, held 0 while deselected
//   DATA_IN  parallel byte to transmit, captured on WRITE
//   WRITE    one-cycle strobe loading DATA_IN into the transmit buffer
//   READ     one-cycle strobe acknowledging RX_DATA (clears RX_FULL, OVERRUN)
//   RX_DATA  last complete received byte
//   RX_FULL  an unread byte is present in RX_DATA
//   TX_FULL  the transmit buffer holds a byte not yet consumed
//   OVERRUN  sticky: a byte completed while RX_FULL was still set
//   BUSY     synchronised CS_N is low
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLK,
  input  logic             CS_N,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             WRITE,
  input  logic             READ,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_FULL,
  output logic             TX_FULL,
  output logic             OVERRUN,
  output logic             BUSY
);

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Input synchronisers plus one extra registered copy for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_dly;
  logic                   cs_dly;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_dly  <= 1'b0;
      cs_dly    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
      cs_dly    <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly;
  assign sclk_fall = ~sclk_s & sclk_dly;
  assign cs_fall   = ~cs_s & cs_dly;
  assign cs_rise   = cs_s & ~cs_dly;

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_next;

  assign rx_next = {mosi_s, rx_shift[WIDTH-1:1]};
  // An empty buffer transmits zeros rather than stale data.
  assign tx_next = TX_FULL ? tx_buf : '0;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_buf   <= '0;
      RX_DATA  <= '0;
      RX_FULL  <= 1'b0;
      TX_FULL  <= 1'b0;
      OVERRUN  <= 1'b0;
      BUSY     <= 1'b0;
      MISO     <= 1'b0;
    end else begin
      if (READ) begin
        RX_FULL <= 1'b0;
        OVERRUN <= 1'b0;
      end
      // A WRITE coincident with a consume still leaves TX_FULL set: the
      // consume below only clears it when no new byte arrives this cycle.
      if (WRITE) begin
        tx_buf  <= DATA_IN;
        TX_FULL <= 1'b1;
      end

      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (cs_fall) begin
            state    <= ACTIVE;
            BUSY     <= 1'b1;
            bit_cnt  <= 4'd0;
            tx_shift <= tx_next;
            MISO     <= tx_next[0];
            if (!WRITE) TX_FULL <= 1'b0;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // Abort: partial receive bits are simply left behind; the counter
            // restart guarantees they are overwritten by the next frame.
            state   <= IDLE;
            BUSY    <= 1'b0;
            bit_cnt <= 4'd0;
            MISO    <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              // Completion takes priority over a coincident READ.
              bit_cnt <= 4'd0;
              RX_DATA <= rx_next;
              RX_FULL <= 1'b1;
              if (RX_FULL && !READ) OVERRUN <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != 4'd0) begin
              tx_shift <= {1'b0, tx_shift[WIDTH-1:1]};
              MISO     <= tx_shift[1];
            end else begin
              // Falling edge after the last bit of a byte: reload for the
              // next byte of a multi-byte frame.
              tx_shift <= tx_next;
              MISO     <= tx_next[0];
              if (!WRITE) TX_FULL <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
